// File: rtl/rf_mport.sv
// rtl/rf_mport.sv - multi-port register file with init walker and pending-write scoreboard
// Optional macro RF_WRITE_FWD_EN forwards same-cycle write data to the pipeline read ports.
module rf_mport #(
  parameter int WIDTH = 32,
  parameter int AW = 5,
  parameter int NREAD = 2,
  parameter int SP_IDX = 2,
  parameter logic [WIDTH-1:0] SP_INIT = 32'h2ffc,
  parameter int GP_IDX = 3,
  parameter logic [WIDTH-1:0] GP_INIT = 32'h1800
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  input  logic                   we0,
  input  logic [AW-1:0]          wa0,
  input  logic [WIDTH-1:0]       wd0,
  input  logic                   we1,
  input  logic [AW-1:0]          wa1,
  input  logic [WIDTH-1:0]       wd1,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic [(1<<AW)-1:0]     pend,
  input  logic [AW-1:0]          ra_dbg,
  output logic [WIDTH-1:0]       rd_dbg,
  output logic                   ready
);

  localparam int N = 1 << AW;
  localparam logic [AW:0] IDX_END = (AW+1)'(N);
  localparam logic [AW-1:0] SP_A = AW'(SP_IDX);
  localparam logic [AW-1:0] GP_A = AW'(GP_IDX);

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW:0]      r_idx, w_idx_inc;
  logic             r_ready, w_ready_nxt;
  logic [WIDTH-1:0] r_regs [N];
  logic [N-1:0]     r_pend, w_pend_nxt;
  logic [WIDTH-1:0] w_init_val;
  logic             w_act, w_c0, w_c1;

  assign w_act     = (r_state == S_READY);
  assign w_c0      = w_act && we0 && (wa0 != '0);
  assign w_c1      = w_act && we1 && (wa1 != '0);
  assign w_idx_inc = r_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = r_ready;
    if (r_state == S_INIT && w_idx_inc == IDX_END) begin
      w_state_nxt = S_READY;
      w_ready_nxt = 1'b1;
    end
  end

  always_comb begin
    w_init_val = '0;
    if (r_idx[AW-1:0] == SP_A)      w_init_val = SP_INIT;
    else if (r_idx[AW-1:0] == GP_A) w_init_val = GP_INIT;
  end

  // Set after clear: a newly issued producer outranks a retiring one.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_act) begin
      if (w_c0)   w_pend_nxt[wa0] = 1'b0;
      if (w_c1)   w_pend_nxt[wa1] = 1'b0;
      if (iss_en) w_pend_nxt[iss_addr] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_pend  <= w_pend_nxt;
      if (r_state == S_INIT) r_idx <= w_idx_inc;
    end
  end

  // Storage has no reset; the walker fills it after every reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_INIT) begin
        r_regs[r_idx[AW-1:0]] <= w_init_val;
      end else begin
        if (w_c0) r_regs[wa0] <= wd0;
        if (w_c1) r_regs[wa1] <= wd1;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic [WIDTH-1:0] w_val;
    assign w_ra = ra[k*AW +: AW];
    always_comb begin
      w_val = r_regs[w_ra];
`ifdef RF_WRITE_FWD_EN
      if (w_c0 && wa0 == w_ra) w_val = wd0;
      if (w_c1 && wa1 == w_ra) w_val = wd1;
`endif
      if (!w_act || w_ra == '0) w_val = '0;
    end
    assign rd[k*WIDTH +: WIDTH] = w_val;
  end

  assign rd_dbg = (w_act && ra_dbg != '0) ? r_regs[ra_dbg] : '0;
  assign pend   = r_pend;
  assign ready  = r_ready;

endmodule
